// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Central pipeline controller. It merges the per-stage stall requests into
//   one thermometer stall vector and sequences exception/ERET redirection
//   coming from MEM: a one-cycle flush pulse, then new_pc held valid until
//   fetch is free to accept it.
//
// Optional feature macro: PIPE_PERF_CNT_EN
//   When defined, the performance counters stall_cycles_o / flush_cnt_o exist.
//   When undefined, both outputs are the constant 32'h0 and no counter flops
//   are built.
//
// Ports
//   cpu_clk_75M     in   CPU clock, all state on posedge
//   cpu_rst_n       in   asynchronous active-low reset
//   stallreq_if     in   fetch / I-side busy (icache refill)
//   stallreq_id     in   load-use hazard
//   stallreq_ex     in   multi-cycle EX operation busy
//   stallreq_mem    in   D-side busy
//   exc_code_i      in   committed exception code from MEM (`EC_None = none)
//   exc_epc_i       in   PC of the faulting instruction (EPC itself lives in CP0)
//   cp0_epc_i       in   current CP0 EPC, target of ERET
//   stall           out  [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB, 1 = stop
//   flush           out  kill all stage registers at next posedge
//   new_pc          out  redirect target, meaningful while new_pc_valid
//   new_pc_valid    out  PC must load new_pc at next unstalled edge
//   ctrl_busy       out  controller is not in RUN
//   stall_cycles_o  out  cycles with stall != 0
//   flush_cnt_o     out  flushes issued
// -----------------------------------------------------------------------------

`ifndef EXC_CODE_WIDTH
`define EXC_CODE_WIDTH 5
`endif
`ifndef EC_None
`define EC_None 5'h10
`endif
`ifndef EC_Ov
`define EC_Ov 5'h0c
`endif
`ifndef EC_ERET
`define EC_ERET 5'h0e
`endif

module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int unsigned FLUSH_HOLD = 1
) (
  input  logic                       cpu_clk_75M,
  input  logic                       cpu_rst_n,
  input  logic                       stallreq_if,
  input  logic                       stallreq_id,
  input  logic                       stallreq_ex,
  input  logic                       stallreq_mem,
  input  logic [`EXC_CODE_WIDTH-1:0] exc_code_i,
  input  logic [31:0]                exc_epc_i,
  input  logic [31:0]                cp0_epc_i,
  output logic [5:0]                 stall,
  output logic                       flush,
  output logic [31:0]                new_pc,
  output logic                       new_pc_valid,
  output logic                       ctrl_busy,
  output logic [31:0]                stall_cycles_o,
  output logic [31:0]                flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_REDIR = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] HOLD_C = FLUSH_HOLD[1:0];

  // Even parity of a 32-bit word.
  function automatic logic parity32(input logic [31:0] d);
    return ^d;
  endfunction

  state_t      state_r, state_nx_s;
  logic [1:0]  mask_r, mask_nx_s;
  logic [31:0] new_pc_r, new_pc_nx_s;
  logic        new_pc_valid_r, new_pc_valid_nx_s;
  logic        take_s;
  logic [5:0]  req_stall_s;
  logic [5:0]  stall_s;

  // EPC is owned by CP0; only its parity is observed here so the port stays live.
  logic        unused_epc_parity_s;
  assign unused_epc_parity_s = parity32(exc_epc_i);

  // An exception is taken only from RUN, outside the post-flush mask window,
  // and never while the D-side is still busy (MEM holds the code stable).
  assign take_s = (state_r == ST_RUN) && (mask_r == 2'd0) &&
                  (exc_code_i != `EC_None) && !stallreq_mem;

  // Priority merge of stall requests: the deepest requester wins.
  always_comb begin
    req_stall_s = 6'b000000;
    if (stallreq_mem) begin
      req_stall_s = 6'b011111;
    end else if (stallreq_ex) begin
      req_stall_s = 6'b001111;
    end else if (stallreq_id) begin
      req_stall_s = 6'b000111;
    end else if (stallreq_if) begin
      req_stall_s = 6'b000011;
    end else begin
      req_stall_s = 6'b000000;
    end
  end

  // Final stall vector: flush overrides everything, DRAIN pins PC/IF.
  always_comb begin
    stall_s = req_stall_s;
    if (take_s) begin
      stall_s = 6'b000000;
    end else if (state_r == ST_DRAIN) begin
      stall_s = req_stall_s | 6'b000011;
    end else begin
      stall_s = req_stall_s;
    end
  end

  // Redirect sequencer next-state logic.
  always_comb begin
    state_nx_s        = state_r;
    new_pc_nx_s       = new_pc_r;
    new_pc_valid_nx_s = new_pc_valid_r;
    mask_nx_s         = (mask_r != 2'd0) ? (mask_r - 2'd1) : mask_r;
    case (state_r)
      ST_RUN: begin
        if (take_s) begin
          new_pc_nx_s       = (exc_code_i == `EC_ERET) ? cp0_epc_i : EXC_VECTOR;
          new_pc_valid_nx_s = 1'b1;
          mask_nx_s         = HOLD_C;
          state_nx_s        = ST_REDIR;
        end else begin
          state_nx_s        = ST_RUN;
        end
      end
      ST_REDIR, ST_DRAIN: begin
        // Fetch busy means it is still refilling the wrong path; keep new_pc.
        if (!stallreq_if) begin
          new_pc_valid_nx_s = 1'b0;
          state_nx_s        = ST_RUN;
        end else begin
          state_nx_s        = ST_DRAIN;
        end
      end
      default: begin
        new_pc_valid_nx_s = 1'b0;
        state_nx_s        = ST_RUN;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_r        <= ST_RUN;
      mask_r         <= 2'd0;
      new_pc_r       <= 32'h0000_0000;
      new_pc_valid_r <= 1'b0;
    end else begin
      state_r        <= state_nx_s;
      mask_r         <= mask_nx_s;
      new_pc_r       <= new_pc_nx_s;
      new_pc_valid_r <= new_pc_valid_nx_s;
    end
  end

  assign stall        = stall_s;
  assign flush        = take_s;
  assign new_pc       = new_pc_r;
  assign new_pc_valid = new_pc_valid_r;
  assign ctrl_busy    = (state_r != ST_RUN);

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Performance counters; both wrap naturally at 32 bits.
  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      stall_cnt_r <= 32'h0000_0000;
      flush_cnt_r <= 32'h0000_0000;
    end else begin
      stall_cnt_r <= (stall_s != 6'b000000) ? (stall_cnt_r + 32'd1) : stall_cnt_r;
      flush_cnt_r <= take_s ? (flush_cnt_r + 32'd1) : flush_cnt_r;
    end
  end

  assign stall_cycles_o = stall_cnt_r;
  assign flush_cnt_o    = flush_cnt_r;
`else
  assign stall_cycles_o = 32'h0000_0000;
  assign flush_cnt_o    = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
`timescale 1ns/1ps

`ifndef EXC_CODE_WIDTH
`define EXC_CODE_WIDTH 5
`endif
`ifndef EC_None
`define EC_None 5'h10
`endif
`ifndef EC_Ov
`define EC_Ov 5'h0c
`endif
`ifndef EC_ERET
`define EC_ERET 5'h0e
`endif

module tb_pipeline_ctrl;

  localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;
  localparam int          HOLD    = 1;

  logic                       cpu_clk_75M = 1'b0;
  logic                       cpu_rst_n;
  logic                       stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [`EXC_CODE_WIDTH-1:0] exc_code_i;
  logic [31:0]                exc_epc_i, cp0_epc_i;
  logic [5:0]                 stall;
  logic                       flush, new_pc_valid, ctrl_busy;
  logic [31:0]                new_pc, stall_cycles_o, flush_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending redirect, its age, mask window and perf counts.
  int          m_phase;   // 0 idle, 1 redirect issued last edge, 2 waiting on fetch
  logic        m_valid;
  logic [31:0] m_pc;
  int          m_mask;
  logic [31:0] m_scnt, m_fcnt;

  typedef struct {
    logic       s_if, s_id, s_ex, s_mem;
    logic [5:0] exp_stall;
  } vec_t;
  vec_t vecs[9];

  always #5 cpu_clk_75M = ~cpu_clk_75M;

  pipeline_ctrl #(.EXC_VECTOR(EXC_VEC), .FLUSH_HOLD(HOLD)) dut (
    .cpu_clk_75M   (cpu_clk_75M),
    .cpu_rst_n     (cpu_rst_n),
    .stallreq_if   (stallreq_if),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .exc_code_i    (exc_code_i),
    .exc_epc_i     (exc_epc_i),
    .cp0_epc_i     (cp0_epc_i),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .new_pc_valid  (new_pc_valid),
    .ctrl_busy     (ctrl_busy),
    .stall_cycles_o(stall_cycles_o),
    .flush_cnt_o   (flush_cnt_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_valid = 1'b0; m_pc = 32'h0; m_mask = 0;
    m_scnt = 32'h0; m_fcnt = 32'h0;
  endtask

  task automatic settle();
    @(negedge cpu_clk_75M);
  endtask

  // Compare outputs with the model (at negedge), advance the model, move to posedge+1.
  task automatic tick();
    int lvl;
    logic take;
    logic [5:0] es;
    take = (m_phase == 0) && (m_mask == 0) && (exc_code_i != `EC_None) && !stallreq_mem;
    lvl  = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : stallreq_if ? 2 : 0;
    es   = take ? 6'd0 : 6'((1 << lvl) - 1);
    if (!take && m_phase == 2 && es < 6'd3) es = 6'b000011;
    chk("model_stall", {26'd0, stall}, {26'd0, es});
    chk("model_flush", {31'd0, flush}, {31'd0, take});
    chk("model_npv", {31'd0, new_pc_valid}, {31'd0, m_valid});
    chk("model_npc", new_pc, m_pc);
    chk("model_busy", {31'd0, ctrl_busy}, {31'd0, (m_phase != 0)});
`ifdef PIPE_PERF_CNT_EN
    chk("model_scnt", stall_cycles_o, m_scnt);
    chk("model_fcnt", flush_cnt_o, m_fcnt);
`else
    chk("scnt_zero", stall_cycles_o, 32'h0);
    chk("fcnt_zero", flush_cnt_o, 32'h0);
`endif
    if (es != 6'd0) m_scnt = m_scnt + 32'd1;
    if (take) m_fcnt = m_fcnt + 32'd1;
    if (m_mask > 0) m_mask--;
    if (take) begin
      m_pc    = (exc_code_i == `EC_ERET) ? cp0_epc_i : EXC_VEC;
      m_valid = 1'b1;
      m_mask  = HOLD;
      m_phase = 1;
    end else if (m_phase != 0) begin
      if (!stallreq_if) begin
        m_valid = 1'b0;
        m_phase = 0;
      end else begin
        m_phase = 2;
      end
    end
    @(posedge cpu_clk_75M);
    #1;
  endtask

  task automatic run_cycle();
    settle();
    tick();
  endtask

  task automatic set_req(input logic a, input logic b, input logic c, input logic d);
    stallreq_if = a; stallreq_id = b; stallreq_ex = c; stallreq_mem = d;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000111};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000011};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b001111};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b011111};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 6'b011111};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000111};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b001111};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};

    cpu_rst_n = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    exc_code_i = `EC_None; exc_epc_i = 32'h0; cp0_epc_i = 32'h0;
    model_reset();
    #12;
    chk("rst_stall", {26'd0, stall}, 32'h0);
    chk("rst_flush", {31'd0, flush}, 32'h0);
    chk("rst_npc", new_pc, 32'h0);
    chk("rst_npv", {31'd0, new_pc_valid}, 32'h0);
    chk("rst_busy", {31'd0, ctrl_busy}, 32'h0);
    chk("rst_scnt", stall_cycles_o, 32'h0);
    chk("rst_fcnt", flush_cnt_o, 32'h0);
    @(negedge cpu_clk_75M);
    cpu_rst_n = 1'b1;
    @(posedge cpu_clk_75M);
    #1;

    // Stall merge table.
    for (int i = 0; i < 9; i++) begin
      set_req(vecs[i].s_if, vecs[i].s_id, vecs[i].s_ex, vecs[i].s_mem);
      settle();
      chk($sformatf("tbl_stall_%0d", i), {26'd0, stall}, {26'd0, vecs[i].exp_stall});
      chk($sformatf("tbl_flush_%0d", i), {31'd0, flush}, 32'h0);
      tick();
    end

    // Overflow with a simultaneous load-use request: exception wins.
    set_req(1'b0, 1'b1, 1'b0, 1'b0);
    exc_code_i = `EC_Ov; exc_epc_i = 32'h8000_0040;
    settle();
    chk("ov_flush", {31'd0, flush}, 32'h1);
    chk("ov_stall", {26'd0, stall}, 32'h0);
    tick();
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    exc_code_i = `EC_None;
    settle();
    chk("ov_npc", new_pc, 32'hBFC0_0380);
    chk("ov_npv", {31'd0, new_pc_valid}, 32'h1);
    chk("ov_busy", {31'd0, ctrl_busy}, 32'h1);
    chk("ov_noflush", {31'd0, flush}, 32'h0);
    tick();
    settle();
    chk("ov_npv_drop", {31'd0, new_pc_valid}, 32'h0);
    chk("ov_run", {31'd0, ctrl_busy}, 32'h0);
    tick();

    // ERET with fetch busy for 3 cycles after the flush.
    exc_code_i = `EC_ERET; cp0_epc_i = 32'h8000_1234;
    settle();
    chk("eret_flush", {31'd0, flush}, 32'h1);
    tick();
    exc_code_i = `EC_Ov;   // belongs to a flushed instruction, must be ignored
    stallreq_if = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("eret_npc", new_pc, 32'h8000_1234);
      chk("eret_npv", {31'd0, new_pc_valid}, 32'h1);
      chk("eret_ignored", {31'd0, flush}, 32'h0);
      if (i > 0) chk("drain_stall", {26'd0, stall}, 32'h3);
      tick();
    end
    exc_code_i = `EC_None;
    stallreq_if = 1'b0;
    settle();
    chk("drain_hold_npv", {31'd0, new_pc_valid}, 32'h1);
    chk("drain_stall_if0", {26'd0, stall}, 32'h3);
    tick();
    settle();
    chk("drain_npv_drop", {31'd0, new_pc_valid}, 32'h0);
    chk("drain_npc_kept", new_pc, 32'h8000_1234);
    tick();

    // Exception waits behind a D-side stall.
    exc_code_i = `EC_Ov; stallreq_mem = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("memwait_noflush", {31'd0, flush}, 32'h0);
      chk("memwait_stall", {26'd0, stall}, 32'h1f);
      tick();
    end
    stallreq_mem = 1'b0;
    settle();
    chk("memwait_flush", {31'd0, flush}, 32'h1);
    tick();
    exc_code_i = `EC_None;
    run_cycle();
    run_cycle();

    // Reset asserted while in DRAIN.
    exc_code_i = `EC_Ov;
    run_cycle();
    exc_code_i = `EC_None; stallreq_if = 1'b1;
    run_cycle();
    run_cycle();
    stallreq_if = 1'b0;
    cpu_rst_n = 1'b0;
    #1;
    chk("arst_stall", {26'd0, stall}, 32'h0);
    chk("arst_flush", {31'd0, flush}, 32'h0);
    chk("arst_npv", {31'd0, new_pc_valid}, 32'h0);
    chk("arst_npc", new_pc, 32'h0);
    chk("arst_busy", {31'd0, ctrl_busy}, 32'h0);
    chk("arst_scnt", stall_cycles_o, 32'h0);
    model_reset();
    @(negedge cpu_clk_75M);
    cpu_rst_n = 1'b1;
    @(posedge cpu_clk_75M);
    #1;
    settle();
    chk("post_rst_stall", {26'd0, stall}, 32'h0);
    tick();
    stallreq_if = 1'b1;
    settle();
    chk("post_rst_req", {26'd0, stall}, 32'h3);
    chk("post_rst_npv", {31'd0, new_pc_valid}, 32'h0);
    tick();
    stallreq_if = 1'b0;

    // Five stalled cycles and two flushes from a fresh count.
    cpu_rst_n = 1'b0;
    model_reset();
    @(negedge cpu_clk_75M);
    cpu_rst_n = 1'b1;
    @(posedge cpu_clk_75M);
    #1;
    stallreq_ex = 1'b1;
    for (int i = 0; i < 5; i++) run_cycle();
    stallreq_ex = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exc_code_i = `EC_Ov;
      run_cycle();
      exc_code_i = `EC_None;
      run_cycle();
    end
    settle();
`ifdef PIPE_PERF_CNT_EN
    chk("perf_stall", stall_cycles_o, 32'd5);
    chk("perf_flush", flush_cnt_o, 32'd2);
`else
    chk("perf_stall_off", stall_cycles_o, 32'd0);
    chk("perf_flush_off", flush_cnt_o, 32'd0);
`endif
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      stallreq_if  = ($urandom_range(0, 3) == 0);
      stallreq_id  = ($urandom_range(0, 3) == 0);
      stallreq_ex  = ($urandom_range(0, 5) == 0);
      stallreq_mem = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 9))
        0:       exc_code_i = `EC_Ov;
        1:       exc_code_i = `EC_ERET;
        2:       exc_code_i = 5'h04;
        default: exc_code_i = `EC_None;
      endcase
      cp0_epc_i = $urandom;
      exc_epc_i = $urandom;
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
